// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared state encoding, address step and burst-length clamp for the DM arbiter.
package dm_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int ADDR_STEP = 4;
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] bmax);
    return (len == 4'd0) ? 4'd1 : (len > bmax) ? bmax : len;
  endfunction
endpackage

// File: rtl/sat_wait_counter.sv
// sat_wait_counter: saturating wait counter with clear priority and a saturation flag.
module sat_wait_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [3:0] cnt;
  assign sat = cnt == 4'(MAX);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 4'd1;
endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: single-port DM arbitration between the CPU MEM stage and a burst DMA engine.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  state_t state;
  logic [3:0] remaining, beats;
  logic [ADDR_W-1:0] burst_addr;
  logic burst_we, cpu_sat, dma_sat, idle;
  assign idle = state == IDLE;
  assign beats = clamp_len(d_len, 4'(BURST_MAX));
  // A CPU grant inside a burst only happens once the CPU has starved; dropping d_req aborts with no grant.
  always_comb begin
    c_gnt   = reset & c_req & (idle ? ~(d_req & dma_sat) : d_req & cpu_sat);
    d_gnt   = reset & d_req & ~c_gnt;
    d_done  = d_gnt & ((idle ? beats : remaining) == 4'd1);
    c_stall = c_req & ~c_gnt;
    m_en    = c_gnt | d_gnt;
    m_we    = c_gnt ? c_we : d_gnt ? (idle ? d_we : burst_we) : 1'b0;
    m_addr  = c_gnt ? c_addr : d_gnt ? (idle ? d_addr : burst_addr) : '0;
    m_wdata = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
  end
  sat_wait_counter #(.MAX(MAX_WAIT)) u_cpu_wait (
    .clk(clk), .reset(reset), .inc(c_req & ~c_gnt), .clr(~c_req | c_gnt), .sat(cpu_sat)
  );
  sat_wait_counter #(.MAX(MAX_WAIT)) u_dma_wait (
    .clk(clk), .reset(reset), .inc(idle & d_req & ~d_gnt), .clr(~d_req | d_gnt), .sat(dma_sat)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      burst_addr <= '0;
      burst_we   <= 1'b0;
    end else if (idle) begin
      if (d_gnt && beats != 4'd1) begin
        state      <= BURST;
        remaining  <= beats - 4'd1;
        burst_addr <= d_addr + ADDR_W'(ADDR_STEP);
        burst_we   <= d_we;
      end
    end else if (!d_req) begin
      state <= IDLE;
    end else if (d_gnt) begin
      burst_addr <= burst_addr + ADDR_W'(ADDR_STEP);
      remaining  <= remaining - 4'd1;
      if (remaining == 4'd1) state <= IDLE;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~m_we;
      if (c_gnt && !c_we) c_rdata <= m_rdata;
      if (d_gnt && !m_we) d_rdata <= m_rdata;
    end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed and random stimulus checked against a cycle-level behavioural model.
module tb_dm_access_arbiter;
  localparam int MAXW = 4;
  localparam int BMAX = 8;
  logic clk = 0, reset = 0;
  logic c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_len = 0;
  logic c_gnt, c_stall, c_rvalid, d_gnt, d_done, d_rvalid, m_en, m_we;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  bit [31:0] mem [256];
  bit [31:0] sh [256];
  int n_cmp = 0, n_err = 0;
  bit mdl_busy = 0, mdl_we = 0;
  int mdl_rem = 0, mdl_cw = 0, mdl_dw = 0;
  logic [31:0] mdl_addr = 0;
  bit eg_c = 0, eg_d = 0, e_done = 0, ewe = 0, exp_crv = 0, exp_drv = 0;
  logic [31:0] ea = 0, ewd = 0, exp_crd = 0, exp_drd = 0;

  dm_access_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [3:0] len);
    return (len == 0) ? 1 : (int'(len) > BMAX) ? BMAX : int'(len);
  endfunction

  task automatic model_reset();
    mdl_busy = 0; mdl_we = 0; mdl_rem = 0; mdl_cw = 0; mdl_dw = 0; mdl_addr = 0;
    exp_crv = 0; exp_drv = 0; exp_crd = 0; exp_drd = 0;
  endtask

  // Called just after a falling edge with inputs settled; predicts and checks this cycle's outputs.
  task automatic eval_check();
    #1;
    if (!mdl_busy) begin
      eg_c = c_req && !(d_req && mdl_dw >= MAXW);
      eg_d = d_req && !eg_c;
      e_done = eg_d && beats_of(d_len) == 1;
    end else begin
      eg_c = d_req && c_req && mdl_cw >= MAXW;
      eg_d = d_req && !eg_c;
      e_done = eg_d && mdl_rem == 1;
    end
    ea  = eg_c ? c_addr : eg_d ? (mdl_busy ? mdl_addr : d_addr) : 32'h0;
    ewe = eg_c ? c_we : eg_d ? (mdl_busy ? mdl_we : d_we) : 1'b0;
    ewd = eg_c ? c_wdata : eg_d ? d_wdata : 32'h0;
    check("c_gnt", c_gnt, eg_c);
    check("d_gnt", d_gnt, eg_d);
    check("d_done", d_done, e_done);
    check("m_en", m_en, eg_c | eg_d);
    check("c_stall", c_stall, c_req && !eg_c);
    check("m_addr", m_addr, ea);
    check("m_we", m_we, ewe);
    check("m_wdata", m_wdata, ewd);
    check("c_rvalid", c_rvalid, exp_crv);
    check("c_rdata", c_rdata, exp_crd);
    check("d_rvalid", d_rvalid, exp_drv);
    check("d_rdata", d_rdata, exp_drd);
  endtask

  task automatic tick();
    @(posedge clk);
    exp_crv = eg_c && !c_we;
    if (exp_crv) exp_crd = sh[c_addr[9:2]];
    exp_drv = eg_d && !ewe;
    if (exp_drv) exp_drd = sh[ea[9:2]];
    if ((eg_c || eg_d) && ewe) sh[ea[9:2]] = ewd;
    mdl_cw = (!c_req || eg_c) ? 0 : (mdl_cw < MAXW ? mdl_cw + 1 : MAXW);
    if (!d_req || eg_d) mdl_dw = 0;
    else if (!mdl_busy) mdl_dw = mdl_dw < MAXW ? mdl_dw + 1 : MAXW;
    if (!mdl_busy) begin
      if (eg_d && beats_of(d_len) > 1) begin
        mdl_busy = 1; mdl_rem = beats_of(d_len) - 1; mdl_addr = d_addr + 32'd4; mdl_we = d_we;
      end
    end else if (!d_req) mdl_busy = 0;
    else if (eg_d) begin
      mdl_addr = mdl_addr + 32'd4;
      mdl_rem--;
      if (mdl_rem == 0) mdl_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    c_req = 0; d_req = 0;
    eval_check();
    tick();
  endtask

  initial begin
    int nb, stalls;
    bit done_seen;
    repeat (2) @(negedge clk);
    check("rst_m_en", m_en, 0);
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 1;
    idle_cycle();
    // CPU write then read back
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    eval_check(); check("t1_wr_gnt", c_gnt, 1); check("t1_wr_stall", c_stall, 0); tick();
    c_we = 0;
    eval_check(); check("t1_rd_gnt", c_gnt, 1); check("t1_rd_stall", c_stall, 0); tick();
    c_req = 0;
    eval_check(); check("t1_rvalid", c_rvalid, 1); check("t1_rdata", c_rdata, 32'hDEADBEEF); tick();
    // DMA write burst of 4
    d_req = 1; d_we = 1; d_addr = 32'h100; d_len = 4;
    for (int i = 0; i < 4; i++) begin
      d_wdata = $urandom;
      eval_check();
      check("t2_gnt", d_gnt, 1);
      check("t2_addr", m_addr, 32'h100 + 32'(4 * i));
      check("t2_done", d_done, i == 3);
      tick();
    end
    d_req = 0;
    eval_check(); check("t2_idle", m_en, 0); tick();
    // Burst of 8 with CPU contending from beat 1
    d_req = 1; d_we = 0; d_addr = 32'h100; d_len = 8;
    eval_check(); tick();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    nb = 1; stalls = 0; done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      eval_check();
      if (c_stall) stalls++;
      if (d_gnt) nb++;
      if (d_done) done_seen = 1;
      if (c_gnt) check("t3_cpu_excl", d_gnt, 0);
      tick();
      if (eg_c) c_req = 0;
    end
    check("t3_stalls", stalls, 4);
    check("t3_beats", nb, 8);
    check("t3_done", done_seen, 1);
    idle_cycle();
    // CPU hogging while DMA waits
    d_req = 1; d_we = 1; d_addr = 32'h300; d_len = 1; c_req = 1; c_we = 1; c_addr = 32'h20;
    for (int k = 0; k < 5; k++) begin
      d_wdata = $urandom; c_wdata = $urandom;
      eval_check();
      check("t4_cgnt", c_gnt, k < 4);
      check("t4_stall", c_stall, k == 4);
      tick();
    end
    idle_cycle();
    // Length clamp: 0 -> 1 beat, 15 -> 8 beats
    d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 0;
    eval_check(); check("t5_len0_done", d_done, 1); tick();
    idle_cycle();
    d_req = 1; d_len = 15; nb = 0; done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      eval_check();
      if (d_gnt) nb++;
      if (d_done) done_seen = 1;
      tick();
    end
    check("t5_len15_beats", nb, 8);
    idle_cycle();
    // Async reset in the middle of a 6-beat burst
    d_req = 1; d_we = 1; d_addr = 32'h80; d_len = 6;
    for (int k = 0; k < 2; k++) begin d_wdata = $urandom; eval_check(); tick(); end
    #2 reset = 0;
    #1;
    check("t6_rst_dgnt", d_gnt, 0);
    check("t6_rst_men", m_en, 0);
    check("t6_rst_maddr", m_addr, 0);
    check("t6_rst_done", d_done, 0);
    check("t6_rst_rvalid", d_rvalid, 0);
    model_reset();
    @(negedge clk);
    reset = 1; d_addr = 32'h200; d_len = 2;
    eval_check(); check("t6_fresh_addr", m_addr, 32'h200); tick();
    eval_check(); check("t6_fresh_done", d_done, 1); tick();
    idle_cycle();
    // Address wrap at the top of the space
    d_req = 1; d_we = 0; d_addr = 32'hFFFFFFF8; d_len = 3;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] wa;
      wa = 32'hFFFFFFF8 + 32'(4 * i);
      eval_check();
      check("t7_wrap_addr", m_addr, wa);
      tick();
    end
    idle_cycle();
    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if (!(c_req && !eg_c)) begin
        c_req = $urandom_range(0, 2) == 0;
        c_we = 1'($urandom);
        c_addr = 32'($urandom_range(0, 255)) << 2;
      end
      c_wdata = $urandom;
      d_wdata = $urandom;
      if (mdl_busy) d_req = $urandom_range(0, 30) != 0;
      else if (!(d_req && !eg_d)) begin
        d_req = $urandom_range(0, 3) == 0;
        d_we = 1'($urandom);
        d_len = 4'($urandom);
        d_addr = (32'($urandom_range(0, 255)) << 2) | ($urandom_range(0, 7) == 0 ? 32'hFFFFFC00 : 32'h0);
      end
      eval_check();
      tick();
    end
    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
